// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, status/control bit positions and serializer states for mmio_uart_tx.
package uart_pkg;
    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQ   = 1;
    localparam int CTRL_FLUSH = 2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with synchronous flush and async active-low reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a push when a pop frees a slot in the same cycle
    assign do_push = push && !flush && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console transmitter; bytes written to TXDATA are queued and sent as 8N1.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_2000,
    parameter int              FIFO_DEPTH = 16,
    parameter int              CLK_HZ     = 100_000_000,
    parameter int              BAUD       = 115_200
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            we_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            sel_o,
    output logic            tx_o,
    output logic            irq_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    tx_state_e       state, state_nx;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg, dout;
    logic [CW-1:0]   count;
    logic [1:0]      idx;
    logic            en, irq_en, ovf, flush_q;
    logic            wr, push, pop, full, empty, busy, baud_last, start_ok;
    logic            unused;
    assign unused    = ^wdata_i[XLEN-1:8];
    assign sel_o     = addr_i >= BASE_ADDR && addr_i <= BASE_ADDR + XLEN'(11);
    assign idx       = 2'((addr_i - BASE_ADDR) >> 2);
    assign wr        = we_i && sel_o;
    assign push      = wr && idx == REG_TXDATA[3:2];
    assign baud_last = baud_cnt == BW'(DIV - 1);
    // no new frame may start in the cycle the flush empties the FIFO
    assign start_ok  = en && !empty && !flush_q;
    assign busy      = state != IDLE;
    assign irq_o     = irq_en && empty && !busy;
    assign tx_o      = state == START ? 1'b0 : state == DATA ? shreg[bit_cnt] : 1'b1;
    assign rdata_o   = !sel_o ? '0
                     : idx == REG_STATUS[3:2] ? XLEN'({8'(count), 4'b0, ovf, busy, empty, full})
                     : idx == REG_CTRL[3:2] ? XLEN'({irq_en, en})
                     : '0;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (flush_q),
        .din   (wdata_i[7:0]),
        .full  (full),
        .empty (empty),
        .count (count),
        .dout  (dout)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en      <= 1'b1;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= wr && idx == REG_CTRL[3:2] && wdata_i[CTRL_FLUSH];
            if (wr && idx == REG_CTRL[3:2]) begin
                en     <= wdata_i[CTRL_EN];
                irq_en <= wdata_i[CTRL_IRQ];
            end
            if (push && full && !pop) ovf <= 1'b1;
            else if (wr && idx == REG_STATUS[3:2] && wdata_i[ST_OVF]) ovf <= 1'b0;
        end
    end
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE:  if (start_ok) begin
                state_nx = START;
                pop      = 1'b1;
            end
            START: if (baud_last) state_nx = DATA;
            DATA:  if (baud_last && bit_cnt == 3'd7) state_nx = STOP;
            STOP:  if (baud_last) begin
                state_nx = start_ok ? START : IDLE;
                pop      = start_ok;
            end
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            baud_cnt <= (pop || state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
            bit_cnt  <= state != DATA ? '0 : bit_cnt + 3'(baud_last);
            if (pop) shreg <= dout;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed scenarios plus random traffic against a frame-timer/queue model of the peripheral.
module tb_mmio_uart_tx;
    localparam int          DIV   = 10;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic        clk = 1'b0, rst_ni = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = 32'h0, wdata_i = 32'h0, rdata_o;
    logic        sel_o, tx_o, irq_o;
    int          checks = 0, errors = 0, cyc = 0;
    bit          chk_en = 1'b0;

    mmio_uart_tx #(.XLEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
        .rdata_o(rdata_o), .sel_o(sel_o), .tx_o(tx_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: a byte queue plus one frame timer counting clocks since the start bit began
    logic [7:0] q[$], sent[$], rx[$];
    int         starts[$];
    bit         m_en = 1'b1, m_irq_en = 1'b0, m_ovf = 1'b0, m_fl = 1'b0, f_act = 1'b0;
    int         f_t = 0, midx;
    logic [7:0] f_byte = 8'h0;
    bit         mw, mgo;

    function automatic bit in_win(logic [31:0] a);
        return a >= BASE && a <= BASE + 32'd11;
    endfunction
    function automatic int reg_idx(logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction
    function automatic logic exp_tx();
        if (!f_act) return 1'b1;
        if (f_t < DIV) return 1'b0;
        if (f_t >= 9 * DIV) return 1'b1;
        return f_byte[f_t / DIV - 1];
    endfunction
    function automatic logic [31:0] exp_rd(logic [31:0] a);
        if (!in_win(a)) return 32'h0;
        if (reg_idx(a) == 1)
            return {16'h0, 8'(q.size()), 4'h0, m_ovf, f_act, q.size() == 0, q.size() == DEPTH};
        if (reg_idx(a) == 2) return {30'h0, m_irq_en, m_en};
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            q.delete();
            m_en = 1'b1; m_irq_en = 1'b0; m_ovf = 1'b0; m_fl = 1'b0; f_act = 1'b0; f_t = 0;
        end else begin
            mw   = we_i && in_win(addr_i);
            midx = reg_idx(addr_i);
            mgo  = m_en && q.size() > 0 && !m_fl;
            if (f_act) begin
                f_t++;
                if (f_t == 10 * DIV) f_act = 1'b0;
            end
            if (!f_act && mgo) begin
                f_byte = q.pop_front();
                sent.push_back(f_byte);
                f_act = 1'b1;
                f_t = 0;
            end
            if (m_fl) q.delete();
            else if (mw && midx == 0) begin
                if (q.size() < DEPTH) q.push_back(wdata_i[7:0]);
                else m_ovf = 1'b1;
            end
            if (mw && midx == 1 && wdata_i[3]) m_ovf = 1'b0;
            if (mw && midx == 2) begin
                m_en = wdata_i[0];
                m_irq_en = wdata_i[1];
            end
            m_fl = mw && midx == 2 && wdata_i[2];
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", 32'(tx_o), 32'(exp_tx()));
            chk("irq", 32'(irq_o), 32'(m_irq_en && q.size() == 0 && !f_act));
            chk("sel", 32'(sel_o), 32'(in_win(addr_i)));
            chk("rdata", rdata_o, exp_rd(addr_i));
        end
    end

    // line monitor: samples mid-bit after each falling start edge
    logic [7:0] mb;
    initial forever begin
        @(negedge clk);
        if (rst_ni && tx_o === 1'b0) begin
            starts.push_back(cyc);
            mb = 8'h0;
            repeat (DIV + DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                mb[i] = tx_o;
                if (i < 7) repeat (DIV) @(negedge clk);
            end
            repeat (DIV) @(negedge clk);
            rx.push_back(mb);
        end
    end

    task automatic wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk); #2;
        addr_i = a; wdata_i = d; we_i = 1'b1;
    endtask
    task automatic idle();
        @(negedge clk); #2;
        we_i = 1'b0; addr_i = 32'h0;
    endtask
    task automatic rd(logic [31:0] a, logic [31:0] e, string n);
        @(negedge clk); #2;
        we_i = 1'b0; addr_i = a; #1;
        chk(n, rdata_o, e);
    endtask
    task automatic waitc(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clr();
        rx.delete(); starts.delete(); sent.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [9:0]  pat;
    logic [31:0] hola;
    int          n, n0, r;
    bit          bad;
    initial begin
        repeat (3) @(negedge clk);
        addr_i = BASE + 32'd4; #1;
        chk("rst_tx", 32'(tx_o), 32'h1);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_status", rdata_o, 32'h2);
        #1 rst_ni = 1'b1;
        chk_en = 1'b1;
        rd(BASE + 32'd8, 32'h1, "rst_ctrl");

        // single 'H' frame, literal waveform
        clr();
        wr(BASE, 32'h48);
        idle();
        chk("t1_latency_high", 32'(tx_o), 32'h1);
        pat = {1'b1, 8'h48, 1'b0};
        for (int s = 0; s < 10; s++) begin
            bad = 1'b0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (tx_o !== pat[s]) bad = 1'b1;
            end
            chk($sformatf("t1_segment%0d_bad", s), 32'(bad), 32'h0);
        end
        waitc(5);
        chk("t1_rx_count", rx.size(), 1);
        if (rx.size() > 0) chk("t1_rx_byte", 32'(rx[0]), 32'h48);

        // "HOLA" back-to-back
        clr();
        hola = 32'h414C_4F48;
        for (int i = 0; i < 4; i++) wr(BASE, 32'(hola[8*i +: 8]));
        idle();
        waitc(430);
        chk("t2_rx_count", rx.size(), 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) chk("t2_rx_byte", 32'(rx[i]), 32'(hola[8*i +: 8]));
        for (int i = 1; i < 4 && i < starts.size(); i++) chk("t2_gap", starts[i] - starts[i-1], 10 * DIV);

        // overflow with EN=0, W1C, then release
        clr();
        wr(BASE + 32'd8, 32'h0);
        for (int i = 0; i < 6; i++) wr(BASE, 32'h30 + i);
        idle();
        rd(BASE + 32'd4, 32'h409, "t3_status_full_ovf");
        wr(BASE + 32'd4, 32'h8);
        idle();
        rd(BASE + 32'd4, 32'h401, "t3_status_w1c");
        wr(BASE + 32'd8, 32'h1);
        idle();
        waitc(430);
        chk("t3_rx_count", rx.size(), 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) chk("t3_rx_byte", 32'(rx[i]), 32'h30 + i);

        // flush during first of three frames
        clr();
        wr(BASE, 32'h11); wr(BASE, 32'h22); wr(BASE, 32'h33);
        idle();
        waitc(30);
        wr(BASE + 32'd8, 32'h5);
        idle();
        waitc(150);
        chk("t4_rx_count", rx.size(), 1);
        if (rx.size() > 0) chk("t4_rx_byte", 32'(rx[0]), 32'h11);
        rd(BASE + 32'd4, 32'h2, "t4_status");
        rd(BASE + 32'd8, 32'h1, "t4_ctrl");

        // async reset in the middle of the data bits
        clr();
        wr(BASE, 32'hA5);
        idle();
        waitc(30);
        #1 addr_i = BASE + 32'd4;
        #1 rst_ni = 1'b0;
        #1;
        chk("t5_rst_tx", 32'(tx_o), 32'h1);
        chk("t5_rst_status", rdata_o, 32'h2);
        waitc(3);
        #2 rst_ni = 1'b1;
        n0 = starts.size();
        waitc(150);
        chk("t5_no_resume", starts.size(), n0);

        // interrupt timing and decode boundaries
        clr();
        wr(BASE + 32'd8, 32'h3);
        idle();
        chk("t6_irq_empty", 32'(irq_o), 32'h1);
        wr(BASE, 32'h5A);
        idle();
        chk("t6_irq_low", 32'(irq_o), 32'h0);
        n = 0;
        while (irq_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t6_irq_return_cycles", n, 10 * DIV + 1);
        #1 addr_i = BASE - 32'd4;
        #1 chk("t6_below_sel", 32'(sel_o), 32'h0);
        chk("t6_below_rdata", rdata_o, 32'h0);
        addr_i = BASE + 32'd12;
        #1 chk("t6_above_sel", 32'(sel_o), 32'h0);
        chk("t6_above_rdata", rdata_o, 32'h0);
        addr_i = BASE + 32'd11;
        #1 chk("t6_ctrl_hi_byte", rdata_o, 32'h3);
        rd(BASE + 32'd5, 32'h2, "t6_status_byte_offset");

        // random traffic against the model
        clr();
        for (int it = 0; it < 2500; it++) begin
            @(negedge clk); #2;
            r = int'($urandom_range(0, 99));
            we_i = 1'b0;
            wdata_i = $urandom;
            if (r < 35) begin
                addr_i = BASE + $urandom_range(0, 3); we_i = 1'b1;
            end else if (r < 40) begin
                addr_i = BASE + 32'd4 + $urandom_range(0, 3); we_i = 1'b1;
            end else if (r < 43) begin
                addr_i = BASE + 32'd8 + $urandom_range(0, 3); we_i = 1'b1;
                wdata_i = 32'h0;
                wdata_i[0] = $urandom_range(0, 4) != 0;
                wdata_i[1] = $urandom_range(0, 1) != 0;
                wdata_i[2] = $urandom_range(0, 3) == 0;
            end else if (r < 55) begin
                addr_i = BASE + $urandom_range(0, 11);
            end else if (r < 60) begin
                addr_i = $urandom_range(0, 1) != 0 ? BASE + 32'd12 + $urandom_range(0, 255)
                                                   : BASE - 32'd1 - $urandom_range(0, 255);
                we_i = 1'b1;
            end else begin
                addr_i = BASE + $urandom_range(0, 15);
            end
        end
        wr(BASE + 32'd8, 32'h1);
        idle();
        n = 0;
        while ((f_act || q.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rand_drain_in_time", 32'(n < 3000), 32'h1);
        waitc(10);
        chk("rand_frame_count", rx.size(), sent.size());
        for (int i = 0; i < rx.size() && i < sent.size(); i++) chk("rand_frame_byte", 32'(rx[i]), 32'(sent[i]));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
